// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// The arbiter takes the slave view; producers and the FIFO model take the master view.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        fifo_full;
    logic                        fifo_almostfull;
    logic                        fifo_wr_en;
    logic [FIFO_WIDTH-1:0]       fifo_data_in;
    logic [OW-1:0]               owner;
    logic                        busy;

    modport slave (
        input  req,
        input  req_data,
        input  fifo_full,
        input  fifo_almostfull,
        output gnt,
        output fifo_wr_en,
        output fifo_data_in,
        output owner,
        output busy
    );

    modport master (
        output req,
        output req_data,
        output fifo_full,
        output fifo_almostfull,
        input  gnt,
        input  fifo_wr_en,
        input  fifo_data_in,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
// Optional build macro FIFO_ARB_PRIO_EN gives requester 0 strict priority at arbitration.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_wr_arbiter_if.slave     bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [OW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;

    logic                    space_ok_s;
    logic                    accept_s;
    logic [N_REQ-1:0]        gnt_s;
    logic [FIFO_WIDTH-1:0]   owner_data_s;

    // Successor index with wrap from the last requester back to 0.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        logic [OW-1:0] res;
        if (idx == LAST_IDX) begin
            res = OW'(0);
        end else begin
            res = idx + OW'(1);
        end
        return res;
    endfunction

    // First active request at or after ptr, scanning with wrap.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    ptr);
        logic [OW-1:0] res;
        logic          found;
        int            j;
        res   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && r[j]) begin
                res   = OW'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Arbitration winner; requester 0 can pre-empt the rotation when priority is built in.
    function automatic logic [OW-1:0] arb_pick(input logic [N_REQ-1:0] r,
                                               input logic [OW-1:0]    ptr);
        logic [OW-1:0] res;
`ifdef FIFO_ARB_PRIO_EN
        if (r[0]) begin
            res = OW'(0);
        end else begin
            res = rr_pick(r, ptr);
        end
`else
        res = rr_pick(r, ptr);
`endif
        return res;
    endfunction

    // Rotation pointer after a grant ends; priority releases of port 0 leave it alone.
    function automatic logic [OW-1:0] release_ptr(input logic [OW-1:0] own,
                                                  input logic [OW-1:0] ptr);
        logic [OW-1:0] res;
`ifdef FIFO_ARB_PRIO_EN
        if (own == OW'(0)) begin
            res = ptr;
        end else begin
            res = next_idx(own);
        end
`else
        res = next_idx(own);
        if (ptr == res) begin
            res = ptr;
        end else begin
            res = next_idx(own);
        end
`endif
        return res;
    endfunction

    // A write already in flight consumes the last free slot, so almostfull blocks too.
    assign space_ok_s   = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);
    assign owner_data_s = bus.req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];

    // Grant decode: only the owner may be granted, never while reset is asserted.
    always_comb begin
        gnt_s = {N_REQ{1'b0}};
        if (rst_n && (state_q == ST_GRANT)) begin
            gnt_s[owner_q] = bus.req[owner_q] & space_ok_s;
        end else begin
            gnt_s = {N_REQ{1'b0}};
        end
    end

    assign accept_s = |(gnt_s & bus.req);

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_d    = arb_pick(bus.req, rr_ptr_q);
                    beat_cnt_d = {BW{1'b0}};
                    state_d    = ST_GRANT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (accept_s) begin
                    wr_en_d    = 1'b1;
                    data_d     = owner_data_s;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if ((beat_cnt_q + BW'(1)) == BURST_MAX) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = release_ptr(owner_q, rr_ptr_q);
                    end else begin
                        state_d  = ST_GRANT;
                    end
                end else if (!bus.req[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = release_ptr(owner_q, rr_ptr_q);
                end else begin
                    state_d  = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= {OW{1'b0}};
            owner_q    <= {OW{1'b0}};
            beat_cnt_q <= {BW{1'b0}};
            wr_en_q    <= 1'b0;
            data_q     <= {FIFO_WIDTH{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt          = gnt_s;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a depth-8 FIFO occupancy model.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 16;
`ifdef FIFO_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .FIFO_WIDTH(W)) bus();

    fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic tb_full, tb_afull, mdl_en, mdl_clr, mdl_ovf;
    int   mdl_pre, mdl_cnt, wr_cnt, stalls;
    int   cyc = 0;
    logic [W-1:0] wr_data [0:63];
    int           wr_cyc  [0:63];

    assign bus.fifo_full       = mdl_en ? (mdl_cnt >= 8) : tb_full;
    assign bus.fifo_almostfull = mdl_en ? (mdl_cnt == 7) : tb_afull;

    // Write log and FIFO occupancy model (no reads).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mdl_clr) begin
            wr_cnt  <= 0;
            mdl_cnt <= mdl_pre;
            mdl_ovf <= 1'b0;
        end else if (bus.fifo_wr_en) begin
            wr_data[wr_cnt[5:0]] <= bus.fifo_data_in;
            wr_cyc[wr_cnt[5:0]]  <= cyc;
            wr_cnt               <= wr_cnt + 1;
            if (mdl_en) begin
                if (mdl_cnt >= 8) mdl_ovf <= 1'b1;
                else              mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        mdl_clr = 1'b1;
        mdl_en  = 1'b0;
        tb_full = 1'b0;
        tb_afull = 1'b0;
        bus.req = 4'b0000;
        tick();
        tick();
        rst_n   = 1'b1;
        mdl_clr = 1'b0;
    endtask

    function automatic int exp_owner(input int burst);
        return PRIO ? 0 : (burst % 4);
    endfunction

    task automatic run_fill(input int pre, input int exp_wr, input bit exp_stall);
        mdl_pre = pre;
        do_reset();
        mdl_en  = 1'b1;
        bus.req = 4'hF;
        stalls  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (bus.fifo_almostfull && bus.fifo_wr_en) begin
                chk("afull_gnt", 32'(bus.gnt), 32'h0);
                if (bus.busy) stalls++;
            end
        end
        bus.req = 4'b0000;
        tick();
        tick();
        #1;
        chk("fill_writes", 32'(wr_cnt), 32'(exp_wr));
        chk("fill_count", 32'(mdl_cnt), 32'd8);
        chk("fill_ovf", 32'(mdl_ovf), 32'h0);
        chk("fill_stall", 32'(stalls > 0), 32'(exp_stall));
    endtask

    initial begin
        bus.req_data = {16'hA030, 16'hA020, 16'hA010, 16'hA000};
        bus.req  = 4'hF;
        rst_n    = 1'b0;
        tb_full  = 1'b0;
        tb_afull = 1'b0;
        mdl_en   = 1'b0;
        mdl_clr  = 1'b1;
        mdl_pre  = 0;

        // 1: reset with all requests active
        tick(); #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        chk("rst_data", 32'(bus.fifo_data_in), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        tick(); #1;
        chk("rst_gnt2", 32'(bus.gnt), 32'h0);

        // 2: round-robin bursts of 4 with one arbitration cycle between
        rst_n   = 1'b1;
        mdl_clr = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(); #1;
            chk("rr_gnt", 32'(bus.gnt),
                ((i % 5) != 4) ? (32'h1 << exp_owner(i / 5)) : 32'h0);
            chk("rr_owner", 32'(bus.owner), 32'(exp_owner(i / 5)));
            chk("rr_wr_en", 32'(bus.fifo_wr_en), 32'((i % 5) != 0));
        end
        bus.req = 4'b0000;
        tick(); tick(); tick(); #1;
        chk("rr_writes", 32'(wr_cnt), 32'd20);
        for (int k = 0; k < 20; k++) begin
            chk("rr_data", 32'(wr_data[k]), 32'h0000A000 | (32'(exp_owner(k / 4)) << 4));
        end
        chk("rr_b2b", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
        chk("rr_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);

        // 3: full throttle then release
        do_reset();
        tb_full = 1'b1;
        bus.req = 4'b0100;
        tick(); #1;
        chk("full_gnt", 32'(bus.gnt), 32'h0);
        chk("full_owner", 32'(bus.owner), 32'd2);
        chk("full_busy", 32'(bus.busy), 32'h1);
        tick(); #1;
        chk("full_gnt2", 32'(bus.gnt), 32'h0);
        chk("full_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        tb_full = 1'b0;
        #1;
        chk("unfull_gnt", 32'(bus.gnt), 32'h4);
        tick(); #1;
        chk("unfull_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        chk("unfull_data", 32'(bus.fifo_data_in), 32'hA020);
        bus.req = 4'b0000;
        tick(); #1;
        chk("unfull_wr_end", 32'(bus.fifo_wr_en), 32'h0);
        chk("unfull_idle", 32'(bus.busy), 32'h0);
        chk("unfull_writes", 32'(wr_cnt), 32'd1);

        // 4: fill a depth-8 FIFO from empty, then from two entries
        run_fill(0, 8, 1'b0);
        run_fill(2, 6, 1'b1);

        // 5: early drop after two beats advances the pointer past the owner
        mdl_pre = 0;
        do_reset();
        bus.req = 4'b0010;
        tick(); #1;
        chk("drop_gnt0", 32'(bus.gnt), 32'h2);
        chk("drop_owner", 32'(bus.owner), 32'd1);
        tick(); #1;
        chk("drop_gnt1", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = 4'b0000;
        #1;
        chk("drop_gnt2", 32'(bus.gnt), 32'h0);
        chk("drop_busy", 32'(bus.busy), 32'h1);
        tick(); #1;
        chk("drop_idle", 32'(bus.busy), 32'h0);
        chk("drop_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        tick(); #1;
        chk("drop_writes", 32'(wr_cnt), 32'd2);
        chk("drop_data", 32'(wr_data[1]), 32'hA010);
        bus.req = 4'b1110;
        tick(); #1;
        chk("drop_next_owner", 32'(bus.owner), 32'd2);
        chk("drop_next_gnt", 32'(bus.gnt), 32'h4);

        // 6: reset mid-burst keeps only the beat accepted before reset
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick(); #1;
        chk("mid_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt_rst", 32'(bus.gnt), 32'h0);
        tick(); #1;
        chk("mid_wr_en_rst", 32'(bus.fifo_wr_en), 32'h0);
        chk("mid_owner", 32'(bus.owner), 32'h0);
        chk("mid_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        tick(); tick(); #1;
        chk("mid_writes", 32'(wr_cnt), 32'd1);

        // 7: port 0 joins during owner 1's burst
        do_reset();
        bus.req = 4'b1010;
        tick(); #1;
        chk("prio_first", 32'(bus.owner), 32'd1);
        bus.req = 4'b1011;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("prio_next", 32'(bus.owner), PRIO ? 32'd0 : 32'd3);
        chk("prio_busy", 32'(bus.busy), 32'h1);
        bus.req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
